// File: rtl/dm_access_ctrl_if.sv
// Pipeline request/response channel plus word-wide data-memory bus for dm_access_ctrl.
interface dm_access_ctrl_if;
    localparam int unsigned XLEN = 32;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [XLEN-1:0]   req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic              resp_valid;
    logic              resp_err;
    logic [XLEN-1:0]   resp_rdata;
    logic              DM_WE;
    logic [XLEN-1:0]   DM_Adr;
    logic [XLEN-1:0]   DM_WDATA;
    logic [XLEN-1:0]   DM_Rdata;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, DM_Rdata,
        input  req_ready, resp_valid, resp_err, resp_rdata, DM_WE, DM_Adr, DM_WDATA
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, DM_Rdata,
        output req_ready, resp_valid, resp_err, resp_rdata, DM_WE, DM_Adr, DM_WDATA
    );
endinterface

// File: rtl/dm_access_ctrl.sv
// Data-memory access controller: byte/half/word loads with extension, sub-word stores
// by read-modify-write, misaligned/out-of-range requests answered with an error.
module dm_access_ctrl #(
    parameter int unsigned DMEM_SIZE  = 1024,
    parameter bit          BIG_ENDIAN = 1'b1
) (
    input logic             CLK,
    input logic             RST,
    dm_access_ctrl_if.slave bus
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ISSUE   = 3'd1;
    localparam logic [2:0] S_CAPTURE = 3'd2;
    localparam logic [2:0] S_WRITE   = 3'd3;
    localparam logic [2:0] S_RESP    = 3'd4;
    localparam logic [2:0] S_ERR     = 3'd5;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    logic [2:0]  state, state_next;
    logic        we_q, uns_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q, merged_q, rdata_q;
    logic        accept, req_bad;
    logic [1:0]  byte_lane;
    logic        half_lane;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_val, merged_val, word_adr;

    assign accept   = bus.req_valid && (state == S_IDLE);
    assign word_adr = {addr_q[31:2], 2'b00};

    // Request legality, evaluated on the live inputs at accept time
    always_comb begin
        req_bad = 1'b0;
        case (bus.req_size)
            SZ_BYTE: req_bad = 1'b0;
            SZ_HALF: req_bad = bus.req_addr[0];
            SZ_WORD: req_bad = |bus.req_addr[1:0];
            SZ_RSVD: req_bad = 1'b1;
            default: req_bad = 1'b1;
        endcase
        if ({2'b00, bus.req_addr[31:2]} >= 32'(DMEM_SIZE)) req_bad = 1'b1;
    end

    // Lane select: in big-endian mode byte offset 0 lives in the top byte
    assign byte_lane = BIG_ENDIAN ? ~addr_q[1:0] : addr_q[1:0];
    assign half_lane = BIG_ENDIAN ? ~addr_q[1]   : addr_q[1];
    assign sel_byte  = bus.DM_Rdata[{byte_lane, 3'b000} +: 8];
    assign sel_half  = bus.DM_Rdata[{half_lane, 4'b0000} +: 16];

    always_comb begin
        case (size_q)
            SZ_BYTE: load_val = {{24{sel_byte[7] & ~uns_q}}, sel_byte};
            SZ_HALF: load_val = {{16{sel_half[15] & ~uns_q}}, sel_half};
            default: load_val = bus.DM_Rdata;
        endcase
    end

    always_comb begin
        merged_val = bus.DM_Rdata;
        if (size_q == SZ_BYTE) merged_val[{byte_lane, 3'b000} +: 8]   = wdata_q[7:0];
        else                   merged_val[{half_lane, 4'b0000} +: 16] = wdata_q[15:0];
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= S_IDLE;
        else     state <= state_next;
    end

    // Request latch and result registers; an error response reports zero load data
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            we_q     <= 1'b0;
            uns_q    <= 1'b0;
            size_q   <= 2'b00;
            addr_q   <= '0;
            wdata_q  <= '0;
            merged_q <= '0;
            rdata_q  <= '0;
        end else begin
            if (accept) begin
                we_q    <= bus.req_we;
                uns_q   <= bus.req_unsigned;
                size_q  <= bus.req_size;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                if (req_bad) rdata_q <= '0;
            end
            if (state == S_CAPTURE) begin
                if (we_q) merged_q <= merged_val;
                else      rdata_q  <= load_val;
            end
        end
    end

    assign bus.resp_rdata = rdata_q;

    // Next state plus memory/handshake decode; DM_* fall to idle values as soon as RST forces IDLE
    always_comb begin
        state_next     = state;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_err   = 1'b0;
        bus.DM_WE      = 1'b0;
        bus.DM_Adr     = '0;
        bus.DM_WDATA   = '0;
        case (state)
            S_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) state_next = req_bad ? S_ERR : S_ISSUE;
            end
            S_ISSUE: begin
                bus.DM_Adr = word_adr;
                if (we_q && (size_q == SZ_WORD)) begin
                    bus.DM_WE    = 1'b1;
                    bus.DM_WDATA = wdata_q;
                    state_next   = S_RESP;
                end else begin
                    state_next   = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                bus.DM_Adr = word_adr;
                state_next = we_q ? S_WRITE : S_RESP;
            end
            S_WRITE: begin
                bus.DM_WE    = 1'b1;
                bus.DM_Adr   = word_adr;
                bus.DM_WDATA = merged_q;
                state_next   = S_RESP;
            end
            S_RESP: begin
                bus.resp_valid = 1'b1;
                state_next     = S_IDLE;
            end
            S_ERR: begin
                bus.resp_valid = 1'b1;
                bus.resp_err   = 1'b1;
                state_next     = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_dm_access_ctrl.sv
// Randomized scoreboard bench for dm_access_ctrl against a byte-addressed memory model.
module tb_dm_access_ctrl;
    localparam int unsigned DMEM_SIZE  = 1024;
    localparam bit          BIG_ENDIAN = 1'b1;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    dm_access_ctrl_if bus();

    dm_access_ctrl #(.DMEM_SIZE(DMEM_SIZE), .BIG_ENDIAN(BIG_ENDIAN)) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit          err;
        logic [31:0] rdata;
        int          we_cycles;
        int          due;
    } exp_t;

    logic [31:0] dut_mem  [DMEM_SIZE];
    logic [7:0]  ref_bytes[DMEM_SIZE*4];
    exp_t        sb[$];
    exp_t        mon_e;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          we_cnt = 0;
    logic [31:0] last_rdata;

    always @(posedge CLK) cyc <= cyc + 1;

    // Word-wide synchronous memory: registered read, read data zero on write cycles
    always @(posedge CLK) begin
        int unsigned idx;
        idx = 32'(bus.DM_Adr[31:2]);
        if (idx < DMEM_SIZE) begin
            if (bus.DM_WE) begin
                dut_mem[idx]  <= bus.DM_WDATA;
                bus.DM_Rdata  <= '0;
            end else begin
                bus.DM_Rdata  <= dut_mem[idx];
            end
        end else begin
            bus.DM_Rdata <= '0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit ref_err(input logic [31:0] a, input logic [1:0] sz);
        return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0)
               || ((a >> 2) >= DMEM_SIZE);
    endfunction

    // Memory seen as a byte array: multi-byte values are stored MSB-first in big-endian mode
    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input bit uns);
        int unsigned i = a;
        logic [7:0]  b;
        logic [15:0] h;
        if (sz == 2'd0) begin
            b = ref_bytes[i];
            return uns ? {24'h0, b} : {{24{b[7]}}, b};
        end
        if (sz == 2'd1) begin
            h = BIG_ENDIAN ? {ref_bytes[i], ref_bytes[i+1]} : {ref_bytes[i+1], ref_bytes[i]};
            return uns ? {16'h0, h} : {{16{h[15]}}, h};
        end
        return BIG_ENDIAN ? {ref_bytes[i], ref_bytes[i+1], ref_bytes[i+2], ref_bytes[i+3]}
                          : {ref_bytes[i+3], ref_bytes[i+2], ref_bytes[i+1], ref_bytes[i]};
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
        int unsigned i = a;
        int n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        for (int k = 0; k < n; k++) begin
            int sh = BIG_ENDIAN ? (n - 1 - k) : k;
            ref_bytes[i + k] = 8'(wd >> (8 * sh));
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge where it is idle again
    task automatic issue(input bit we, input logic [1:0] sz, input bit uns,
                         input logic [31:0] a, input logic [31:0] wd, input bit hold);
        exp_t e;
        int   lat, t, busy;
        e.err = ref_err(a, sz);
        if (e.err) begin
            lat = 1; e.rdata = '0; e.we_cycles = 0; last_rdata = '0;
        end else if (!we) begin
            lat = 3; e.rdata = ref_load(a, sz, uns); e.we_cycles = 0; last_rdata = e.rdata;
        end else begin
            lat = (sz == 2'd2) ? 2 : 4; e.rdata = last_rdata; e.we_cycles = 1;
            ref_store(a, sz, wd);
        end
        bus.req_we = we; bus.req_size = sz; bus.req_unsigned = uns;
        bus.req_addr = a; bus.req_wdata = wd; bus.req_valid = 1'b1;
        t = 0;
        while (!bus.req_ready && t < 50) begin @(negedge CLK); t++; end
        if (!bus.req_ready) begin
            check("accept_timeout", 32'(bus.req_ready), 32'd1);
            bus.req_valid = 1'b0;
            return;
        end
        @(posedge CLK); #1;
        e.due = cyc + lat - 1;
        sb.push_back(e);
        @(negedge CLK);
        if (!hold) begin
            bus.req_valid = 1'b0; bus.req_we = 1'($urandom); bus.req_size = 2'($urandom);
            bus.req_addr = $urandom; bus.req_wdata = $urandom;
        end
        busy = 0;
        while (!bus.req_ready && busy < 10) begin busy++; @(negedge CLK); end
        bus.req_valid = 1'b0;
        check("busy_cycles", 32'(busy), 32'(lat));
    endtask

    // Scoreboard monitor: pops one expectation per response pulse
    always @(negedge CLK) begin
        if (RST) begin
            we_cnt = 0;
        end else begin
            if (bus.DM_WE) we_cnt++;
            if (bus.resp_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_resp", 32'(bus.resp_valid), 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("resp_err",     32'(bus.resp_err), 32'(mon_e.err));
                    check("resp_rdata",   bus.resp_rdata,    mon_e.rdata);
                    check("resp_latency", 32'(cyc),          32'(mon_e.due));
                    check("we_cycles",    32'(we_cnt),       32'(mon_e.we_cycles));
                end
                we_cnt = 0;
            end
        end
    end

    initial begin
        int t;
        bit we, uns;
        logic [1:0]  sz;
        logic [31:0] a;
        for (int w = 0; w < int'(DMEM_SIZE); w++) begin
            dut_mem[w] = $urandom;
            for (int k = 0; k < 4; k++)
                ref_bytes[4*w + k] = BIG_ENDIAN ? dut_mem[w][31 - 8*k -: 8] : dut_mem[w][8*k +: 8];
        end
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00; bus.req_unsigned = 1'b0;
        bus.req_addr = '0; bus.req_wdata = '0;
        last_rdata = '0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_req_ready",  32'(bus.req_ready),  32'd1);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_resp_err",   32'(bus.resp_err),   32'd0);
        check("rst_resp_rdata", bus.resp_rdata,      32'd0);
        check("rst_dm_we",      32'(bus.DM_WE),      32'd0);
        check("rst_dm_adr",     bus.DM_Adr,          32'd0);
        check("rst_dm_wdata",   bus.DM_WDATA,        32'd0);
        RST = 1'b0;
        @(negedge CLK);

        // Word store/load, sub-word loads, byte RMW
        issue(1, 2'd2, 0, 32'h10, 32'h11223344, 0);
        issue(0, 2'd2, 0, 32'h10, 32'h0, 0);
        issue(0, 2'd0, 1, 32'h13, 32'h0, 0);
        issue(0, 2'd1, 0, 32'h10, 32'h0, 0);
        issue(0, 2'd1, 1, 32'h12, 32'h0, 0);
        issue(1, 2'd0, 0, 32'h12, 32'hABCDEF80, 0);
        issue(0, 2'd0, 0, 32'h12, 32'h0, 0);
        issue(0, 2'd0, 1, 32'h12, 32'h0, 0);
        issue(0, 2'd2, 0, 32'h10, 32'h0, 0);
        // Misaligned, reserved size, out of range, then confirm the word is untouched
        issue(0, 2'd2, 0, 32'h12, 32'h0, 0);
        issue(1, 2'd1, 0, 32'h11, 32'hDEADBEEF, 0);
        issue(1, 2'd3, 0, 32'h10, 32'hDEADBEEF, 0);
        issue(1, 2'd2, 0, DMEM_SIZE*4, 32'hCAFEF00D, 0);
        issue(0, 2'd0, 1, DMEM_SIZE*4 + 3, 32'h0, 0);
        issue(0, 2'd2, 0, 32'h10, 32'h0, 1);
        issue(1, 2'd1, 0, 32'h16, 32'h1234, 1);
        issue(0, 2'd2, 0, 32'h14, 32'h0, 1);

        // Reset during the write phase of a halfword RMW
        issue(1, 2'd2, 0, 32'h20, 32'h55667788, 0);
        bus.req_we = 1'b1; bus.req_size = 2'd1; bus.req_unsigned = 1'b0;
        bus.req_addr = 32'h20; bus.req_wdata = 32'h0000BEEF; bus.req_valid = 1'b1;
        @(posedge CLK); #1;
        bus.req_valid = 1'b0;
        @(posedge CLK); @(posedge CLK); #1;
        check("abort_we_in_write", 32'(bus.DM_WE), 32'd1);
        RST = 1'b1;
        #1;
        check("abort_we_dropped",  32'(bus.DM_WE),      32'd0);
        check("abort_no_resp",     32'(bus.resp_valid), 32'd0);
        check("abort_idle",        32'(bus.req_ready),  32'd1);
        last_rdata = '0;
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        issue(0, 2'd2, 0, 32'h20, 32'h0, 0);
        issue(0, 2'd1, 1, 32'h20, 32'h0, 0);

        // Random traffic, concentrated on a small window so stores and loads collide
        for (int n = 0; n < 400; n++) begin
            int r;
            we  = 1'($urandom);
            uns = 1'($urandom);
            sz  = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            r   = $urandom_range(0, 9);
            if (r == 0)      a = $urandom;
            else if (r == 1) a = DMEM_SIZE*4 + $urandom_range(0, 7);
            else if (r == 2) a = $urandom_range(0, DMEM_SIZE*4 - 1);
            else             a = $urandom_range(0, 127);
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz == 2'd2) a[1:0] = 2'b00;
            end
            issue(we, sz, uns, a, $urandom, 1'($urandom));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge CLK);
        end

        t = 0;
        while (sb.size() != 0 && t < 20) begin @(negedge CLK); t++; end
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
